pwm_reg_bank: RTL and testbench

//  Bus-side register bank that sits directly upstream of perip_PWM and drives its

---
 rtl/pwm_reg_bank.sv | 136 +++++++++++++
 tb/tb_pwm_reg_bank.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_reg_bank.sv
// rtl/pwm_reg_bank.sv - shadow/active register bank feeding perip_PWM with period-aligned commit
// Active regs change only on a PWM period boundary (or one cycle after an IMMEDIATE commit).
module pwm_reg_bank #(
    parameter logic [31:0] DEF_FREQ = 32'd9999,
    parameter logic [31:0] DEF_DUTY = 32'd0
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        BUS_WE,
    input  logic        BUS_RE,
    input  logic [3:0]  BUS_ADDR,
    input  logic [31:0] BUS_WDATA,
    output logic [31:0] BUS_RDATA,
    output logic        BUS_RVALID,
    output logic [31:0] FREQ_Cnt_Set,
    output logic [31:0] CH0_duty_Set,
    output logic [31:0] CH1_duty_Set,
    output logic [31:0] CH2_duty_Set,
    output logic [31:0] CH3_duty_Set,
    output logic [31:0] CH4_duty_Set,
    output logic [31:0] CH5_duty_Set,
    output logic [31:0] CH6_duty_Set,
    output logic [31:0] CH7_duty_Set,
    output logic        UPDATE_DONE
);

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    // Index 0 is FREQ, indices 1..8 are CH0..CH7 duty, matching the address map.
    logic [31:0] shadow_q [9];
    logic [31:0] active_q [9];

    state_t      state_q, state_d;
    logic [31:0] mcnt_q;
    logic [31:0] period_cnt_q;
    logic        ctrl_imm_q;
    logic        imm_q, imm_d;
    logic        upd_q;
    logic [31:0] rdata_q;
    logic        rvalid_q;

    logic        boundary;
    logic        commit_wr;
    logic        pend_copy;
    logic        copy;
    logic [31:0] rd_mux;

    assign boundary  = (mcnt_q >= active_q[0]);
    assign commit_wr = BUS_WE && (BUS_ADDR == 4'd9) && BUS_WDATA[0];
    assign copy      = pend_copy || imm_q;

    always_comb begin
        state_d   = state_q;
        imm_d     = 1'b0;
        pend_copy = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (commit_wr) begin
                    if (ctrl_imm_q) imm_d   = 1'b1;
                    else            state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (boundary) begin
                    pend_copy = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        if (BUS_ADDR <= 4'd8) begin
            rd_mux = shadow_q[BUS_ADDR];
        end else begin
            case (BUS_ADDR)
                4'd9:    rd_mux = {30'd0, ctrl_imm_q, 1'b0};
                4'd10:   rd_mux = {31'd0, state_q == S_PENDING};
                4'd11:   rd_mux = period_cnt_q;
                4'd12:   rd_mux = active_q[0];
                default: rd_mux = 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= S_IDLE;
            mcnt_q       <= 32'd0;
            period_cnt_q <= 32'd0;
            ctrl_imm_q   <= 1'b0;
            imm_q        <= 1'b0;
            upd_q        <= 1'b0;
            rdata_q      <= 32'd0;
            rvalid_q     <= 1'b0;
            shadow_q[0]  <= DEF_FREQ;
            active_q[0]  <= DEF_FREQ;
            for (int i = 1; i < 9; i++) begin
                shadow_q[i] <= DEF_DUTY;
                active_q[i] <= DEF_DUTY;
            end
        end else begin
            state_q  <= state_d;
            imm_q    <= imm_d;
            upd_q    <= copy;
            rvalid_q <= BUS_RE;
            mcnt_q   <= boundary ? 32'd0 : mcnt_q + 32'd1;
            if (boundary) period_cnt_q <= period_cnt_q + 32'd1;
            // Copy samples the pre-write shadow; a same-cycle write lands in the shadow only.
            if (copy) begin
                for (int i = 0; i < 9; i++) active_q[i] <= shadow_q[i];
            end
            if (BUS_RE) rdata_q <= rd_mux;
            if (BUS_WE) begin
                if (BUS_ADDR <= 4'd8)  shadow_q[BUS_ADDR] <= BUS_WDATA;
                if (BUS_ADDR == 4'd9)  ctrl_imm_q         <= BUS_WDATA[1];
            end
        end
    end

    assign BUS_RDATA    = rdata_q;
    assign BUS_RVALID   = rvalid_q;
    assign UPDATE_DONE  = upd_q;
    assign FREQ_Cnt_Set = active_q[0];
    assign CH0_duty_Set = active_q[1];
    assign CH1_duty_Set = active_q[2];
    assign CH2_duty_Set = active_q[3];
    assign CH3_duty_Set = active_q[4];
    assign CH4_duty_Set = active_q[5];
    assign CH5_duty_Set = active_q[6];
    assign CH6_duty_Set = active_q[7];
    assign CH7_duty_Set = active_q[8];

endmodule

// File: tb/tb_pwm_reg_bank.sv
// tb/tb_pwm_reg_bank.sv - self-checking bench for pwm_reg_bank
module tb_pwm_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0, re = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        rvalid, upd;
    logic [31:0] freq_o;
    logic [31:0] duty_o [8];

    int vectors = 0;
    int miscompares = 0;
    int n_upd = 0;

    always #5 clk = ~clk;

    pwm_reg_bank dut (
        .CLK(clk), .RST_n(rst_n),
        .BUS_WE(we), .BUS_RE(re), .BUS_ADDR(addr), .BUS_WDATA(wdata),
        .BUS_RDATA(rdata), .BUS_RVALID(rvalid),
        .FREQ_Cnt_Set(freq_o),
        .CH0_duty_Set(duty_o[0]), .CH1_duty_Set(duty_o[1]),
        .CH2_duty_Set(duty_o[2]), .CH3_duty_Set(duty_o[3]),
        .CH4_duty_Set(duty_o[4]), .CH5_duty_Set(duty_o[5]),
        .CH6_duty_Set(duty_o[6]), .CH7_duty_Set(duty_o[7]),
        .UPDATE_DONE(upd)
    );

    // Reference model: register file view of the bank, advanced once per clock.
    logic [31:0] m_sh [9];
    logic [31:0] m_act [9];
    logic [31:0] m_mcnt, m_pcnt, m_rdata;
    logic        m_pend, m_imm_bit, m_imm_go, m_upd, m_rvalid;

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a <= 4'd8)  return m_sh[a];
        if (a == 4'd9)  return {30'd0, m_imm_bit, 1'b0};
        if (a == 4'd10) return {31'd0, m_pend};
        if (a == 4'd11) return m_pcnt;
        if (a == 4'd12) return m_act[0];
        return 32'd0;
    endfunction

    task automatic m_reset();
        m_sh[0] = 32'd9999; m_act[0] = 32'd9999;
        for (int i = 1; i < 9; i++) begin m_sh[i] = 32'd0; m_act[i] = 32'd0; end
        m_mcnt = 0; m_pcnt = 0; m_rdata = 0;
        m_pend = 0; m_imm_bit = 0; m_imm_go = 0; m_upd = 0; m_rvalid = 0;
    endtask

    task automatic m_step();
        logic        at_boundary, do_copy, is_commit;
        logic [31:0] snap [9];
        at_boundary = (m_mcnt >= m_act[0]);
        do_copy     = (m_pend && at_boundary) || m_imm_go;
        is_commit   = we && addr == 4'd9 && wdata[0];
        for (int i = 0; i < 9; i++) snap[i] = m_sh[i];
        m_rvalid = re;
        if (re) m_rdata = m_read(addr);
        m_upd = do_copy;
        if (do_copy) for (int i = 0; i < 9; i++) m_act[i] = snap[i];
        if (at_boundary) begin m_mcnt = 0; m_pcnt = m_pcnt + 1; end
        else m_mcnt = m_mcnt + 1;
        m_imm_go = is_commit && !m_pend && m_imm_bit;
        if (m_pend) begin
            if (at_boundary) m_pend = 0;
        end else if (is_commit && !m_imm_bit) begin
            m_pend = 1;
        end
        if (we && addr <= 4'd8) m_sh[addr] = wdata;
        if (we && addr == 4'd9) m_imm_bit = wdata[1];
    endtask

    initial m_reset();
    always @(negedge rst_n) m_reset();
    always @(posedge clk) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled away from the rising edge.
    always @(negedge clk) begin
        check("FREQ_Cnt_Set", freq_o, m_act[0]);
        for (int i = 0; i < 8; i++) check($sformatf("CH%0d_duty_Set", i), duty_o[i], m_act[i+1]);
        check("UPDATE_DONE", {31'd0, upd}, {31'd0, m_upd});
        check("BUS_RVALID", {31'd0, rvalid}, {31'd0, m_rvalid});
        check("BUS_RDATA", rdata, m_rdata);
        if (upd) n_upd++;
    end

    task automatic cyc();
        @(negedge clk); #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we = 1; addr = a; wdata = d; cyc(); we = 0;
    endtask

    task automatic rd(input logic [3:0] a);
        re = 1; addr = a; cyc(); re = 0;
    endtask

    int          u0, guard;
    logic [31:0] p0;

    initial begin
        repeat (3) cyc();
        rst_n = 1;
        cyc();

        // 1: reset values and read latency
        rd(4'd0);  check("rst_freq_shadow", rdata, 32'd9999);
        check("rvalid_after_re", {31'd0, rvalid}, 32'd1);
        cyc();     check("rvalid_one_cycle", {31'd0, rvalid}, 32'd0);
        rd(4'd1);  check("rst_ch0_shadow", rdata, 32'd0);
        rd(4'd12); check("rst_active_freq", rdata, 32'd9999);

        // 2: commit waits for the default-period boundary
        wr(4'd0, 32'd99); wr(4'd1, 32'd50); wr(4'd9, 32'd1);
        rd(4'd10); check("status_pending", rdata, 32'd1);
        check("freq_before_boundary", freq_o, 32'd9999);
        u0 = n_upd; guard = 0;
        while (!upd && guard < 12000) begin cyc(); guard++; end
        check("commit2_timeout", {31'd0, guard >= 12000}, 32'd0);
        check("freq_after_commit", freq_o, 32'd99);
        check("ch0_after_commit", duty_o[0], 32'd50);
        repeat (20) cyc();
        check("commit2_single_pulse", n_upd - u0, 32'd1);
        rd(4'd10); check("status_idle", rdata, 32'd0);

        // 3: immediate commit
        wr(4'd9, 32'd2); wr(4'd4, 32'd7); wr(4'd9, 32'd3);
        check("imm_ch3_not_yet", duty_o[3], 32'd0);
        cyc();
        check("imm_ch3_applied", duty_o[3], 32'd7);
        wr(4'd9, 32'd0);

        // 4: shadow write on the boundary/copy cycle
        wr(4'd2, 32'd5); wr(4'd9, 32'd1);
        guard = 0;
        while (m_mcnt < m_act[0] && guard < 500) begin cyc(); guard++; end
        wr(4'd2, 32'd20);
        cyc();
        check("boundary_write_ch1_active", duty_o[1], 32'd5);
        rd(4'd2); check("boundary_write_ch1_shadow", rdata, 32'd20);

        // 5: double commit, FREQ=3 period counting
        u0 = n_upd;
        wr(4'd0, 32'd3); wr(4'd9, 32'd1); wr(4'd9, 32'd1);
        repeat (300) cyc();
        check("double_commit_one_pulse", n_upd - u0, 32'd1);
        check("freq3_active", freq_o, 32'd3);
        rd(4'd11); p0 = rdata;
        repeat (3) cyc();
        rd(4'd11); check("period_cnt_every_4", rdata - p0, 32'd1);

        // 6: reset while pending
        wr(4'd0, 32'd200); wr(4'd9, 32'd1);
        u0 = n_upd;
        rst_n = 0;
        repeat (3) cyc();
        check("rst_freq_def", freq_o, 32'd9999);
        check("rst_ch0_def", duty_o[0], 32'd0);
        rst_n = 1;
        rd(4'd10); check("rst_status_zero", rdata, 32'd0);
        repeat (50) cyc();
        check("rst_no_update", n_upd - u0, 32'd0);

        // Randomized traffic; small FREQ values keep boundaries frequent.
        wr(4'd0, 32'd5); wr(4'd9, 32'd1);
        repeat (3000) begin
            we = ($urandom_range(0, 2) == 0);
            re = ($urandom_range(0, 2) == 0);
            addr = 4'($urandom_range(0, 15));
            wdata = $urandom;
            if (addr == 4'd0) wdata = $urandom_range(0, 15);
            if (addr == 4'd9) wdata = {30'd0, 2'($urandom_range(0, 3))};
            cyc();
        end
        we = 0; re = 0;
        repeat (5) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
